// File: rtl/pwm_pkg.sv
// Shared defaults and the saturating ramp helper for pwm_motor_ctrl.
package pwm_pkg;

    localparam int unsigned WDef        = 8;
    localparam int unsigned DutyFastDef = 180;
    localparam int unsigned DutySlowDef = 150;
    localparam int unsigned StepDef     = 4;

    // Move cur toward tgt by at most step; lands exactly on tgt when closer than step.
    function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                             input logic [31:0] tgt,
                                             input logic [31:0] step);
        logic [31:0] res;
        if (cur < tgt) begin
            res = ((tgt - cur) > step) ? cur + step : tgt;
        end else begin
            res = ((cur - tgt) > step) ? cur - step : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: latched fast/slow target, active duty and compare against the shared
// counter. PWM_RAMP_EN selects soft-start ramping of the active duty toward the target.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int unsigned W         = WDef,
    parameter int unsigned DUTY_FAST = DutyFastDef,
    parameter int unsigned DUTY_SLOW = DutySlowDef,
    parameter int unsigned STEP      = StepDef
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run_i,       // en & ~ir; low clears the duty and silences pwm
    input  logic         boundary_i,  // last cycle of the period
    input  logic         tin_i,
    input  logic [W-1:0] cnt_i,
    output logic         pwm_o,
    output logic         fast_o
);

    localparam logic [W-1:0] FastV = W'(DUTY_FAST);
    localparam logic [W-1:0] SlowV = W'(DUTY_SLOW);

    logic         fast_q, fast_d;
    logic [W-1:0] duty_q, duty_d;
    logic         pwm_q, pwm_d;
    logic [W-1:0] target;
    logic [W-1:0] duty_next;

    // Target being latched at this boundary; the duty moves toward it in the same edge.
    assign target = tin_i ? FastV : SlowV;

`ifdef PWM_RAMP_EN
    assign duty_next = W'(sat_step(32'(duty_q), 32'(target), STEP));
`else
    assign duty_next = target;
    logic unused_step;
    assign unused_step = ^STEP;
`endif

    // Next-state: target latch at boundary, duty cleared on stop, compare registered.
    always_comb begin
        fast_d = fast_q;
        duty_d = duty_q;
        if (boundary_i) begin
            fast_d = tin_i;
        end
        if (!run_i) begin
            duty_d = '0;
        end else if (boundary_i) begin
            duty_d = duty_next;
        end
        pwm_d = run_i & (cnt_i < duty_q);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_q <= 1'b0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            fast_q <= fast_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign fast_o = fast_q;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// Multi-channel PWM motor controller: shared period counter, obstacle stop and status LEDs.
// Define PWM_RAMP_EN to soft-start each channel's duty instead of loading it directly.
module pwm_motor_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CH        = 2,
    parameter int unsigned W         = WDef,
    parameter int unsigned DUTY_FAST = DutyFastDef,
    parameter int unsigned DUTY_SLOW = DutySlowDef,
    parameter int unsigned STEP      = StepDef
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ir,
    input  logic [CH-1:0] tin,
    output logic [CH-1:0] pwm,
    output logic          led1,
    output logic [CH-1:0] led2,
    output logic          period_tick
);

    localparam logic [W-1:0] CntMax = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;
    logic         led1_q, led1_d;
    logic         run;
    logic         boundary;

    assign run      = en & ~ir;
    assign boundary = en & (cnt_q == CntMax);

    // Counter runs only while enabled and parks at zero otherwise.
    always_comb begin
        cnt_d  = en ? cnt_q + 1'b1 : '0;
        tick_d = boundary;
        led1_d = run;
    end

    // Shared counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            led1_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            led1_q <= led1_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        pwm_chan #(
            .W        (W),
            .DUTY_FAST(DUTY_FAST),
            .DUTY_SLOW(DUTY_SLOW),
            .STEP     (STEP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .run_i     (run),
            .boundary_i(boundary),
            .tin_i     (tin[i]),
            .cnt_i     (cnt_q),
            .pwm_o     (pwm[i]),
            .fast_o    (led2[i])
        );
    end

    assign led1        = led1_q;
    assign period_tick = tick_q;

endmodule
